cog_segment_accumulator: RTL and testbench

Downstream stage of the CoG receiver FSM. Consumes the registered pixel/figure stream (image byte, valid, figure start/end markers, start column, end-of-line/frame, new-frame) and reduces every figure run on a line into one segment record: line index, start column, length, intensity sum and intensity-weighted column sum. Records leave on a valid/ready interface towards the per-figure CoG solver; the input side is never back-pressured.

---
 rtl/cog_segment_accumulator.sv | 206 ++++++++++++++++++++
 tb/tb_cog_segment_accumulator.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cog_segment_accumulator.sv
// Reduces each figure run on a line of the CoG pixel stream into one segment record
// (line, start column, length, intensity sum, intensity-weighted column sum) on a valid/ready port.
module cog_segment_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 1024,
    parameter int MIN_LEN    = 3
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_aresetn,
    input  logic [DATA_WIDTH-1:0]  i_data_image,
    input  logic                   i_data_valid,
    input  logic [10:0]            i_start_point,
    input  logic                   i_start_of_fig,
    input  logic                   i_end_of_fig,
    input  logic                   i_end_of_line,
    input  logic                   i_end_of_frame,
    input  logic                   i_new_frame,
    output logic                   o_seg_valid,
    input  logic                   i_seg_ready,
    output logic [10:0]            o_seg_line,
    output logic [10:0]            o_seg_start,
    output logic [11:0]            o_seg_len,
    output logic [DATA_WIDTH+10:0] o_seg_sum_i,
    output logic [DATA_WIDTH+21:0] o_seg_sum_ix,
    output logic                   o_frame_done,
    output logic                   o_overflow,
    output logic                   o_seg_error
);

    localparam int SUMI_W  = DATA_WIDTH + 11;
    localparam int SUMIX_W = DATA_WIDTH + 22;

    if ((WIDTH < 1) || (WIDTH > 2048) || (HEIGHT < 1) || (HEIGHT > 2048)) begin : g_geom_check
        $error("cog_segment_accumulator: WIDTH and HEIGHT must lie in 1..2048");
    end

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SEG = 2'd1,
        ST_ACCUM    = 2'd2
    } state_t;

    function automatic logic [SUMI_W-1:0] pix_times_col(input logic [DATA_WIDTH-1:0] pix,
                                                        input logic [10:0]           col);
        return {{11{1'b0}}, pix} * {{DATA_WIDTH{1'b0}}, col};
    endfunction

    state_t               state_q, state_d;
    logic [10:0]          x_q, x_d, start_q, start_d, line_q, line_d;
    logic [11:0]          len_q, len_d;
    logic [SUMI_W-1:0]    sum_i_q, sum_i_d;
    logic [SUMIX_W-1:0]   sum_ix_q, sum_ix_d;
    logic                 seg_valid_q, seg_valid_d;
    logic [10:0]          seg_line_q, seg_line_d, seg_start_q, seg_start_d;
    logic [11:0]          seg_len_q, seg_len_d;
    logic [SUMI_W-1:0]    seg_sum_i_q, seg_sum_i_d;
    logic [SUMIX_W-1:0]   seg_sum_ix_q, seg_sum_ix_d;
    logic                 frame_done_q, frame_done_d, overflow_q, overflow_d, error_q, error_d;
    logic                 start_s, step_s, open_s, fin_s, keep_s;
    logic [10:0]          x_next_s;

    // Segment tracking, line counter and output record register next-state logic
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        start_d      = start_q;
        len_d        = len_q;
        sum_i_d      = sum_i_q;
        sum_ix_d     = sum_ix_q;
        line_d       = line_q;
        seg_valid_d  = seg_valid_q;
        seg_line_d   = seg_line_q;
        seg_start_d  = seg_start_q;
        seg_len_d    = seg_len_q;
        seg_sum_i_d  = seg_sum_i_q;
        seg_sum_ix_d = seg_sum_ix_q;
        frame_done_d = 1'b0;
        overflow_d   = overflow_q;
        error_d      = error_q;
        start_s      = 1'b0;
        step_s       = 1'b0;
        open_s       = 1'b0;
        fin_s        = 1'b0;
        keep_s       = 1'b0;
        x_next_s     = x_q + 11'd1;

        case (state_q)
            ST_IDLE: begin
                if (i_new_frame) begin
                    state_d    = ST_WAIT_SEG;
                    line_d     = 11'd0;
                    overflow_d = 1'b0;
                    error_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_SEG, ST_ACCUM: begin
                start_s = i_data_valid & i_start_of_fig;
                step_s  = i_data_valid & ~i_start_of_fig & (state_q == ST_ACCUM);
                if (start_s) begin
                    // A start inside an open segment cuts the old one short
                    error_d  = error_q | (state_q == ST_ACCUM);
                    start_d  = i_start_point;
                    x_d      = i_start_point;
                    len_d    = 12'd1;
                    sum_i_d  = SUMI_W'(i_data_image);
                    sum_ix_d = SUMIX_W'(pix_times_col(i_data_image, i_start_point));
                    fin_s    = i_end_of_fig;
                    open_s   = ~i_end_of_fig;
                end else if (step_s) begin
                    x_d      = x_next_s;
                    len_d    = len_q + 12'd1;
                    sum_i_d  = sum_i_q + SUMI_W'(i_data_image);
                    sum_ix_d = sum_ix_q + SUMIX_W'(pix_times_col(i_data_image, x_next_s));
                    fin_s    = i_end_of_fig;
                    open_s   = ~i_end_of_fig;
                end else begin
                    open_s = (state_q == ST_ACCUM);
                end
                // Status pulses act after any same-cycle finalize and abort what is still open
                if (open_s && (i_end_of_line || i_end_of_frame || i_new_frame)) begin
                    error_d = 1'b1;
                end else begin
                    error_d = error_d;
                end
                line_d = i_new_frame ? 11'd0 :
                         (i_end_of_line && (line_q != 11'd2047)) ? line_q + 11'd1 : line_q;
                state_d = i_new_frame    ? ST_WAIT_SEG :
                          i_end_of_frame ? ST_IDLE :
                          (open_s && !i_end_of_line) ? ST_ACCUM : ST_WAIT_SEG;
                frame_done_d = i_end_of_frame;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        keep_s = fin_s && (len_d >= 12'(MIN_LEN));
        if (keep_s && (!seg_valid_q || i_seg_ready)) begin
            seg_valid_d  = 1'b1;
            seg_line_d   = line_q;
            seg_start_d  = start_d;
            seg_len_d    = len_d;
            seg_sum_i_d  = sum_i_d;
            seg_sum_ix_d = sum_ix_d;
        end else if (keep_s) begin
            overflow_d = 1'b1;
        end else if (seg_valid_q && i_seg_ready) begin
            seg_valid_d = 1'b0;
        end else begin
            seg_valid_d = seg_valid_q;
        end
    end

    // State, accumulator and output registers
    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state_q      <= ST_IDLE;
            x_q          <= 11'd0;
            start_q      <= 11'd0;
            len_q        <= 12'd0;
            sum_i_q      <= '0;
            sum_ix_q     <= '0;
            line_q       <= 11'd0;
            seg_valid_q  <= 1'b0;
            seg_line_q   <= 11'd0;
            seg_start_q  <= 11'd0;
            seg_len_q    <= 12'd0;
            seg_sum_i_q  <= '0;
            seg_sum_ix_q <= '0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            start_q      <= start_d;
            len_q        <= len_d;
            sum_i_q      <= sum_i_d;
            sum_ix_q     <= sum_ix_d;
            line_q       <= line_d;
            seg_valid_q  <= seg_valid_d;
            seg_line_q   <= seg_line_d;
            seg_start_q  <= seg_start_d;
            seg_len_q    <= seg_len_d;
            seg_sum_i_q  <= seg_sum_i_d;
            seg_sum_ix_q <= seg_sum_ix_d;
            frame_done_q <= frame_done_d;
            overflow_q   <= overflow_d;
            error_q      <= error_d;
        end
    end

    assign o_seg_valid  = seg_valid_q;
    assign o_seg_line   = seg_line_q;
    assign o_seg_start  = seg_start_q;
    assign o_seg_len    = seg_len_q;
    assign o_seg_sum_i  = seg_sum_i_q;
    assign o_seg_sum_ix = seg_sum_ix_q;
    assign o_frame_done = frame_done_q;
    assign o_overflow   = overflow_q;
    assign o_seg_error  = error_q;

endmodule

// File: tb/tb_cog_segment_accumulator.sv
// Directed self-checking bench for cog_segment_accumulator with hand-computed segment records.
module tb_cog_segment_accumulator;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        valid = 1'b0;
    logic [10:0] sp = 11'd0;
    logic        sof = 1'b0, eofig = 1'b0, eol = 1'b0, eofr = 1'b0, nf = 1'b0;
    logic        ready = 1'b1;
    logic        seg_valid, frame_done, overflow, seg_error;
    logic [10:0] seg_line, seg_start;
    logic [11:0] seg_len;
    logic [18:0] sum_i;
    logic [29:0] sum_ix;
    int          n_cmp = 0;
    int          n_fail = 0;

    cog_segment_accumulator dut (
        .i_sys_clk(clk), .i_sys_aresetn(rstn), .i_data_image(data), .i_data_valid(valid),
        .i_start_point(sp), .i_start_of_fig(sof), .i_end_of_fig(eofig), .i_end_of_line(eol),
        .i_end_of_frame(eofr), .i_new_frame(nf), .o_seg_valid(seg_valid), .i_seg_ready(ready),
        .o_seg_line(seg_line), .o_seg_start(seg_start), .o_seg_len(seg_len), .o_seg_sum_i(sum_i),
        .o_seg_sum_ix(sum_ix), .o_frame_done(frame_done), .o_overflow(overflow), .o_seg_error(seg_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        valid = 1'b0; sof = 1'b0; eofig = 1'b0; eol = 1'b0; eofr = 1'b0; nf = 1'b0; data = 8'hEE;
    endtask

    task automatic send_px(input logic [7:0] d, input logic s, input logic e, input logic [10:0] col);
        data = d; valid = 1'b1; sof = s; eofig = e; sp = col;
        tick();
    endtask

    task automatic test_reset();
        tick(); tick();
        n_cmp++; if ({seg_valid, seg_line, seg_start, seg_len, sum_i, sum_ix, frame_done, overflow, seg_error} !== 87'd0) begin n_fail++; $display("FAIL reset_outputs: got nonzero outputs, expected all 0"); end
        rstn = 1'b1;
        send_px(8'd1, 1'b1, 1'b0, 11'd5);
        send_px(8'd2, 1'b0, 1'b0, 11'd0);
        send_px(8'd3, 1'b0, 1'b1, 11'd0);
        n_cmp++; if (seg_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ignore: got valid=%0b expected 0", seg_valid); end
        n_cmp++; if (seg_error !== 1'b0) begin n_fail++; $display("FAIL idle_error: got %0b expected 0", seg_error); end
    endtask

    task automatic test_basic();
        nf = 1'b1; tick();
        send_px(8'd10, 1'b1, 1'b0, 11'd100);
        n_cmp++; if (seg_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: got valid=%0b expected 0", seg_valid); end
        send_px(8'd20, 1'b0, 1'b0, 11'd0);
        send_px(8'd30, 1'b0, 1'b1, 11'd0);
        n_cmp++; if (seg_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b expected 1", seg_valid); end
        n_cmp++; if (seg_line !== 11'd0) begin n_fail++; $display("FAIL basic_line: got %0d expected 0", seg_line); end
        n_cmp++; if (seg_start !== 11'd100) begin n_fail++; $display("FAIL basic_start: got %0d expected 100", seg_start); end
        n_cmp++; if (seg_len !== 12'd3) begin n_fail++; $display("FAIL basic_len: got %0d expected 3", seg_len); end
        n_cmp++; if (sum_i !== 19'd60) begin n_fail++; $display("FAIL basic_sum_i: got %0d expected 60", sum_i); end
        n_cmp++; if (sum_ix !== 30'd6080) begin n_fail++; $display("FAIL basic_sum_ix: got %0d expected 6080", sum_ix); end
        tick();
        n_cmp++; if (seg_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got valid=%0b expected 0", seg_valid); end
    endtask

    task automatic test_short();
        send_px(8'd255, 1'b1, 1'b0, 11'd40);
        send_px(8'd255, 1'b0, 1'b1, 11'd0);
        n_cmp++; if (seg_valid !== 1'b0) begin n_fail++; $display("FAIL short_valid: got %0b expected 0", seg_valid); end
        n_cmp++; if (seg_error !== 1'b0) begin n_fail++; $display("FAIL short_error: got %0b expected 0", seg_error); end
    endtask

    task automatic test_gaps();
        send_px(8'd5, 1'b1, 1'b0, 11'd7);
        tick(); tick();
        send_px(8'd5, 1'b0, 1'b0, 11'd0);
        tick(); tick();
        send_px(8'd5, 1'b0, 1'b0, 11'd0);
        tick(); tick();
        send_px(8'd5, 1'b0, 1'b1, 11'd0);
        n_cmp++; if (seg_start !== 11'd7) begin n_fail++; $display("FAIL gaps_start: got %0d expected 7", seg_start); end
        n_cmp++; if (seg_len !== 12'd4) begin n_fail++; $display("FAIL gaps_len: got %0d expected 4", seg_len); end
        n_cmp++; if (sum_i !== 19'd20) begin n_fail++; $display("FAIL gaps_sum_i: got %0d expected 20", sum_i); end
        n_cmp++; if (sum_ix !== 30'd170) begin n_fail++; $display("FAIL gaps_sum_ix: got %0d expected 170", sum_ix); end
        tick();
    endtask

    task automatic test_overflow();
        ready = 1'b0;
        send_px(8'd1, 1'b1, 1'b0, 11'd10);
        send_px(8'd2, 1'b0, 1'b0, 11'd0);
        send_px(8'd3, 1'b0, 1'b1, 11'd0);
        n_cmp++; if ({seg_valid, sum_ix} !== {1'b1, 30'd68}) begin n_fail++; $display("FAIL ovf_first: got valid=%0b sum_ix=%0d expected 1/68", seg_valid, sum_ix); end
        n_cmp++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %0b expected 0", overflow); end
        tick();
        send_px(8'd4, 1'b1, 1'b0, 11'd50);
        send_px(8'd4, 1'b0, 1'b0, 11'd0);
        send_px(8'd4, 1'b0, 1'b1, 11'd0);
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
        n_cmp++; if (seg_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_hold_valid: got %0b expected 1", seg_valid); end
        n_cmp++; if (seg_start !== 11'd10) begin n_fail++; $display("FAIL ovf_hold_start: got %0d expected 10", seg_start); end
        n_cmp++; if (sum_i !== 19'd6) begin n_fail++; $display("FAIL ovf_hold_sum_i: got %0d expected 6", sum_i); end
        n_cmp++; if (sum_ix !== 30'd68) begin n_fail++; $display("FAIL ovf_hold_sum_ix: got %0d expected 68", sum_ix); end
        ready = 1'b1;
        tick();
        n_cmp++; if (seg_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_release: got valid=%0b expected 0", seg_valid); end
        n_cmp++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %0b expected 1", overflow); end
    endtask

    task automatic test_eol_eof();
        for (int i = 0; i < 5; i++) begin
            eol = 1'b1;
            tick();
        end
        send_px(8'd1, 1'b1, 1'b0, 11'd200);
        send_px(8'd1, 1'b0, 1'b0, 11'd0);
        eol = 1'b1; eofr = 1'b1;
        send_px(8'd1, 1'b0, 1'b1, 11'd0);
        n_cmp++; if (seg_valid !== 1'b1) begin n_fail++; $display("FAIL eof_valid: got %0b expected 1", seg_valid); end
        n_cmp++; if (seg_line !== 11'd5) begin n_fail++; $display("FAIL eof_line: got %0d expected 5", seg_line); end
        n_cmp++; if ({seg_start, seg_len} !== {11'd200, 12'd3}) begin n_fail++; $display("FAIL eof_start_len: got %0d/%0d expected 200/3", seg_start, seg_len); end
        n_cmp++; if ({sum_i, sum_ix} !== {19'd3, 30'd603}) begin n_fail++; $display("FAIL eof_sums: got %0d/%0d expected 3/603", sum_i, sum_ix); end
        n_cmp++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL eof_done: got %0b expected 1", frame_done); end
        n_cmp++; if (seg_error !== 1'b0) begin n_fail++; $display("FAIL eof_error: got %0b expected 0", seg_error); end
        tick();
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL eof_done_width: got %0b expected 0", frame_done); end
        send_px(8'd9, 1'b1, 1'b0, 11'd300);
        send_px(8'd9, 1'b0, 1'b0, 11'd0);
        send_px(8'd9, 1'b0, 1'b1, 11'd0);
        n_cmp++; if (seg_valid !== 1'b0) begin n_fail++; $display("FAIL eof_idle_ignore: got %0b expected 0", seg_valid); end
    endtask

    task automatic test_abort_reset();
        nf = 1'b1; tick();
        n_cmp++; if ({overflow, seg_error} !== 2'b00) begin n_fail++; $display("FAIL nf_clear: got %0b%0b expected 00", overflow, seg_error); end
        send_px(8'd1, 1'b1, 1'b0, 11'd20);
        send_px(8'd2, 1'b0, 1'b0, 11'd0);
        eol = 1'b1;
        send_px(8'd3, 1'b0, 1'b0, 11'd0);
        n_cmp++; if (seg_error !== 1'b1) begin n_fail++; $display("FAIL abort_error: got %0b expected 1", seg_error); end
        n_cmp++; if (seg_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_record: got %0b expected 0", seg_valid); end
        send_px(8'd3, 1'b1, 1'b0, 11'd0);
        send_px(8'd3, 1'b0, 1'b0, 11'd0);
        rstn = 1'b0;
        #2;
        n_cmp++; if ({seg_valid, seg_line, seg_start, seg_len, sum_i, sum_ix, frame_done, overflow, seg_error} !== 87'd0) begin n_fail++; $display("FAIL mid_reset: got nonzero outputs, expected all 0"); end
        tick();
        rstn = 1'b1;
        send_px(8'd3, 1'b0, 1'b1, 11'd0);
        n_cmp++; if ({seg_valid, seg_error} !== 2'b00) begin n_fail++; $display("FAIL post_reset: got valid=%0b err=%0b expected 0/0", seg_valid, seg_error); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_short();
        test_gaps();
        test_overflow();
        test_eol_eof();
        test_abort_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
